mod_exp_engine: RTL and testbench

//  Sequential modular exponentiation: result = base^exponent mod p.

---
 rtl/mod_exp_engine.sv | 169 ++++++++++++++++
 tb/tb_mod_exp_engine.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mod_exp_engine.sv
// Constant-time modular exponentiation, square-and-always-multiply, scanning the exponent MSB first.
// Each modular multiply is interleaved (Blakley): one multiplier bit per clock.
//   state  | meaning
//   IDLE   | wait for start; operands are latched on accept
//   LOAD   | R=1, set up the bit indices, check the operands
//   SQR    | T = R*R mod p, P_W cycles
//   MUL    | T2 = T*base mod p, P_W cycles; R = exp bit ? T2 : T
//   FINISH | publish result, raise done on the next edge
module mod_exp_engine #(
  parameter int P_W = 32,
  parameter int E_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [P_W-1:0] base,
  input  logic [E_W-1:0] exponent,
  input  logic [P_W-1:0] p,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [63:0]    result
);

  localparam int IW = (E_W > 1) ? $clog2(E_W) : 1;
  localparam int JW = (P_W > 1) ? $clog2(P_W) : 1;
  localparam int AW = P_W + 2;

  typedef enum logic [2:0] {IDLE, LOAD, SQR, MUL, FINISH} state_t;

  state_t         state_q, state_d;
  logic [P_W-1:0] base_q, base_d, p_q, p_d, r_q, r_d, t_q, t_d;
  logic [E_W-1:0] exp_q, exp_d;
  logic [IW-1:0]  i_q, i_d;
  logic [JW-1:0]  j_q, j_d;
  logic [AW-1:0]  acc_q, acc_d;
  logic           busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [63:0]    result_q, result_d;

  logic [P_W-1:0] op_a, op_b;
  logic           b_bit;
  logic [AW-1:0]  p_ext, dbl, dbl_red, sum, sum_red;

  // One Blakley step; acc stays below p, so AW bits never overflow.
  always_comb begin
    op_a    = (state_q == SQR) ? r_q : t_q;
    op_b    = (state_q == SQR) ? r_q : base_q;
    b_bit   = op_b[j_q];
    p_ext   = {2'b00, p_q};
    dbl     = acc_q << 1;
    dbl_red = (dbl >= p_ext) ? (dbl - p_ext) : dbl;
    sum     = dbl_red + (b_bit ? {2'b00, op_a} : '0);
    sum_red = (sum >= p_ext) ? (sum - p_ext) : sum;
  end

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    p_d      = p_q;
    exp_d    = exp_q;
    r_d      = r_q;
    t_d      = t_q;
    i_d      = i_q;
    j_d      = j_q;
    acc_d    = acc_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        // done_q guard keeps the done cycle itself from accepting a new job
        if (start && !done_q) begin
          base_d  = base;
          exp_d   = exponent;
          p_d     = p;
          busy_d  = 1'b1;
          err_d   = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        r_d   = P_W'(1);
        i_d   = IW'(E_W - 1);
        j_d   = JW'(P_W - 1);
        acc_d = '0;
        if (p_q < P_W'(2) || base_q >= p_q) begin
          err_d    = 1'b1;
          result_d = '0;
          state_d  = FINISH;
        end else begin
          state_d = SQR;
        end
      end
      SQR: begin
        acc_d = sum_red;
        if (j_q == '0) begin
          t_d     = sum_red[P_W-1:0];
          acc_d   = '0;
          j_d     = JW'(P_W - 1);
          state_d = MUL;
        end else begin
          j_d = j_q - 1'b1;
        end
      end
      MUL: begin
        acc_d = sum_red;
        if (j_q == '0) begin
          r_d   = exp_q[i_q] ? sum_red[P_W-1:0] : t_q;
          acc_d = '0;
          j_d   = JW'(P_W - 1);
          if (i_q == '0) begin
            state_d = FINISH;
          end else begin
            i_d     = i_q - 1'b1;
            state_d = SQR;
          end
        end else begin
          j_d = j_q - 1'b1;
        end
      end
      FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        if (!err_q) result_d = 64'(r_q);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      base_q   <= '0;
      p_q      <= '0;
      exp_q    <= '0;
      r_q      <= '0;
      t_q      <= '0;
      i_q      <= '0;
      j_q      <= '0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      p_q      <= p_d;
      exp_q    <= exp_d;
      r_q      <= r_d;
      t_q      <= t_d;
      i_q      <= i_d;
      j_q      <= j_d;
      acc_q    <= acc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign result = result_q;

endmodule

// File: tb/tb_mod_exp_engine.sv
// Scoreboard bench for mod_exp_engine: stimulus pushes expected result/err/done-cycle,
// a negedge monitor pops and compares on every done pulse.
module tb_mod_exp_engine;

  localparam int LAT_OK  = 2050;
  localparam int LAT_ERR = 2;
  localparam logic [31:0] BIGP = 32'd4294967291;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base = '0;
  logic [31:0] exponent = '0;
  logic [31:0] p = '0;
  logic        busy, done, err;
  logic [63:0] result;

  typedef struct {
    logic [63:0] res;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          done_count = 0;
  int          pushed = 0;
  int          acc_cyc = 0;
  logic [63:0] last_result = '0;

  mod_exp_engine dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .exponent(exponent), .p(p),
    .busy(busy), .done(done), .err(err), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      done_count++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("err", {63'd0, err}, {63'd0, e.err});
        chk("latency", 64'(cyc), 64'(e.cyc));
        chk("busy_at_done", {63'd0, busy}, 64'd0);
      end
    end
  end

  task automatic issue(input logic [31:0] b, input logic [31:0] e, input logic [31:0] pp);
    @(negedge clk);
    base = b; exponent = e; p = pp; start = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    start = 1'b0;
    base = $urandom; exponent = $urandom; p = $urandom;
    chk("err_cleared_on_accept", {63'd0, err}, 64'd0);
    chk("result_held_on_accept", result, last_result);
    chk("busy_after_accept", {63'd0, busy}, 64'd1);
  endtask

  task automatic push_exp(input logic [63:0] res, input logic er, input int lat);
    exp_t e;
    e.res = res; e.err = er; e.cyc = acc_cyc + lat;
    sb.push_back(e);
    pushed++;
    last_result = res;
  endtask

  task automatic wait_empty(input int lat);
    for (int k = 0; k < lat + 20 && sb.size() != 0; k++) @(posedge clk);
    if (sb.size() != 0) begin
      chk("done_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  task automatic run_job(input logic [31:0] b, input logic [31:0] e, input logic [31:0] pp,
                         input logic [63:0] res, input logic er);
    int lat;
    lat = er ? LAT_ERR : LAT_OK;
    issue(b, e, pp);
    push_exp(res, er, lat);
    wait_empty(lat);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_err", {63'd0, err}, 64'd0);
    chk("reset_result", result, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_job(32'd5, 32'd6, 32'd23, 64'd8, 1'b0);
    run_job(32'd2, 32'd0, 32'd23, 64'd1, 1'b0);
    run_job(32'd0, 32'd7, 32'd23, 64'd0, 1'b0);
    run_job(BIGP - 32'd1, 32'd2, BIGP, 64'd1, 1'b0);
    run_job(BIGP - 32'd1, 32'd3, BIGP, 64'd4294967290, 1'b0);
    run_job(32'd0, 32'd5, 32'd1, 64'd0, 1'b1);
    run_job(32'd30, 32'd5, 32'd23, 64'd0, 1'b1);
    run_job(32'd3, 32'd5, 32'd23, 64'd13, 1'b0);

    // second start mid-job must be ignored
    issue(32'd5, 32'd6, 32'd23);
    push_exp(64'd8, 1'b0, LAT_OK);
    repeat (99) @(posedge clk);
    @(negedge clk);
    base = 32'd2; exponent = 32'd0; p = 32'd23; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_ignored_start", {63'd0, busy}, 64'd1);
    wait_empty(LAT_OK);
    repeat (LAT_OK + 20) @(posedge clk);
    chk("single_done_count", 64'(done_count), 64'(pushed));

    // reset mid-job aborts with no done
    issue(32'd7, 32'd9, 32'd23);
    repeat (499) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_result", result, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    last_result = '0;
    repeat (LAT_OK + 20) @(posedge clk);
    chk("no_done_after_abort", 64'(done_count), 64'(pushed));

    // 7^9 mod 23: 7^2=3, 7^4=9, 7^8=12, *7 = 84 mod 23 = 15
    run_job(32'd7, 32'd9, 32'd23, 64'd15, 1'b0);

    repeat (5) @(posedge clk);
    chk("final_done_count", 64'(done_count), 64'(pushed));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
